// File: rtl/clcd_pkg.sv
// Shared types and constants for the character-LCD request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Macro CLCD_INIT_SEQ_EN adds the INIT state and init table.
package clcd_pkg;

  // Default timing, in core clocks
  localparam int SETUP_CYC_DEF   = 2;
  localparam int PULSE_CYC_DEF   = 4;
  localparam int HOLD_CYC_DEF    = 2;
  localparam int EXEC_CYC_DEF    = 50;
  localparam int LONG_CYC_DEF    = 2000;
  localparam int POWERUP_CYC_DEF = 20000;

  // HD44780-style command bytes (RS=0)
  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_HOME       = 8'h02;

  // Encodings are fixed so dropping INIT does not shift the others
  typedef enum logic [2:0] {
    PWRUP = 3'd0,
`ifdef CLCD_INIT_SEQ_EN
    INIT  = 3'd1,
`endif
    IDLE  = 3'd2,
    SETUP = 3'd3,
    PULSE = 3'd4,
    HOLD  = 3'd5,
    WAIT  = 3'd6
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and home need the long execution wait
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

`ifdef CLCD_INIT_SEQ_EN
  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = CMD_FUNC_SET;
      2'd1:    init_cmd = CMD_DISP_ON;
      2'd2:    init_cmd = CMD_ENTRY_MODE;
      default: init_cmd = CMD_CLEAR;
    endcase
  endfunction
`endif

endpackage

// File: rtl/clcd_byte_timer.sv
// Drives one latched byte onto the LCD bus: SETUP, PULSE (E high), HOLD, then execution WAIT.
// Latency: start accepted in IDLE; done pulses on the last WAIT clock, IDLE again the next clock.
// Backpressure: start is only honoured while phase_o is IDLE; callers must wait for that.
module clcd_byte_timer
  import clcd_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF,
  parameter int EXEC_CYC  = EXEC_CYC_DEF,
  parameter int LONG_CYC  = LONG_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output state_t     phase_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  localparam int MAX_CYC = max2(max2(SETUP_CYC, PULSE_CYC),
                                max2(HOLD_CYC, max2(EXEC_CYC, LONG_CYC)));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYC - 1);

  state_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, long_q;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] wait_last;

  assign wait_last = long_q ? LONG_LAST : EXEC_LAST;

  // Phase sequencing; the counter restarts at zero on every phase change
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + 1'b1;
    done_o  = 1'b0;
    case (phase_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) phase_d = SETUP;
      end
      SETUP: if (cnt_q == SETUP_LAST) begin phase_d = PULSE; cnt_d = '0; end
      PULSE: if (cnt_q == PULSE_LAST) begin phase_d = HOLD;  cnt_d = '0; end
      HOLD:  if (cnt_q == HOLD_LAST)  begin phase_d = WAIT;  cnt_d = '0; end
      WAIT: if (cnt_q == wait_last) begin
        phase_d = IDLE;
        cnt_d   = '0;
        done_o  = 1'b1;
      end
      default: begin
        phase_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Phase and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Byte latch; held on the bus until the next start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else if ((phase_q == IDLE) && start_i) begin
      rs_q   <= rs_i;
      data_q <= data_i;
      long_q <= is_long_cmd(rs_i, data_i);
    end
  end

  assign phase_o    = phase_q;
  assign lcd_e_o    = (phase_q == PULSE);
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/clcd_req_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of a write-only character LCD.
// Latency: ready is combinational in IDLE; a byte occupies the bus 1+SETUP+PULSE+HOLD+EXEC/LONG clocks.
// Backpressure: requesters hold valid until ready; CLCD_INIT_SEQ_EN adds the power-on INIT table.
module clcd_req_arbiter
  import clcd_pkg::*;
#(
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int PULSE_CYC   = PULSE_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int EXEC_CYC    = EXEC_CYC_DEF,
  parameter int LONG_CYC    = LONG_CYC_DEF,
  parameter int POWERUP_CYC = POWERUP_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       busy,
  output logic       grant_id,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int               PWR_W    = $clog2(POWERUP_CYC + 1);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYC - 1);

  state_t           state_q, state_d;
  logic [PWR_W-1:0] pwr_cnt_q, pwr_cnt_d;
  logic             lock_q, lock_d;           // owner is last_q while set
  logic             last_q, last_d;           // last granted requester
  logic             grant_q, grant_d;
  logic             byte_last_q, byte_last_d; // last flag of the byte on the bus
`ifdef CLCD_INIT_SEQ_EN
  logic [1:0]       idx_q, idx_d;
`endif

  logic       tmr_start, tmr_rs, tmr_done, tmr_idle;
  logic [7:0] tmr_data;
  state_t     tmr_phase;
  logic       gnt_vld, gnt_id, accept;
  logic       sel_rs, sel_last;
  logic [7:0] sel_data;

  clcd_byte_timer #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .HOLD_CYC  (HOLD_CYC),
    .EXEC_CYC  (EXEC_CYC),
    .LONG_CYC  (LONG_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start_i    (tmr_start),
    .rs_i       (tmr_rs),
    .data_i     (tmr_data),
    .done_o     (tmr_done),
    .phase_o    (tmr_phase),
    .lcd_e_o    (LCD_E),
    .lcd_rs_o   (LCD_RS),
    .lcd_data_o (LCD_DATA)
  );

  assign tmr_idle = (tmr_phase == IDLE);

  // Round-robin pick, pinned to the lock owner while a burst is open
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (lock_q) begin
      gnt_id  = last_q;
      gnt_vld = last_q ? req1_valid : req0_valid;
    end else if (req0_valid && req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = ~last_q;
    end else if (req0_valid) begin
      gnt_vld = 1'b1;
    end else if (req1_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  assign accept   = (state_q == IDLE) && tmr_idle && gnt_vld;
  assign sel_rs   = gnt_id ? req1_rs   : req0_rs;
  assign sel_data = gnt_id ? req1_data : req0_data;
  assign sel_last = gnt_id ? req1_last : req0_last;

  // Top-level sequencing: power-up delay, optional init table, then arbitration
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = '0;
    lock_d      = lock_q;
    last_d      = last_q;
    grant_d     = grant_q;
    byte_last_d = byte_last_q;
    tmr_start   = 1'b0;
    tmr_rs      = 1'b0;
    tmr_data    = 8'h00;
`ifdef CLCD_INIT_SEQ_EN
    idx_d       = idx_q;
`endif
    case (state_q)
      PWRUP: begin
        if (pwr_cnt_q == PWR_LAST) begin
`ifdef CLCD_INIT_SEQ_EN
          state_d = INIT;
`else
          state_d = IDLE;
`endif
        end else begin
          pwr_cnt_d = pwr_cnt_q + 1'b1;
        end
      end
`ifdef CLCD_INIT_SEQ_EN
      INIT: begin
        if (tmr_idle) begin
          tmr_start = 1'b1;
          tmr_data  = init_cmd(idx_q);
        end
        if (tmr_done) begin
          if (idx_q == 2'(INIT_LEN - 1)) state_d = IDLE;
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      IDLE: begin
        if (accept) begin
          tmr_start   = 1'b1;
          tmr_rs      = sel_rs;
          tmr_data    = sel_data;
          grant_d     = gnt_id;
          last_d      = gnt_id;
          byte_last_d = sel_last;
          if (!sel_last) lock_d = 1'b1;
        end
        // The burst closes only once its final byte has finished executing
        if (tmr_done && byte_last_q) lock_d = 1'b0;
      end
      default: state_d = PWRUP;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWRUP;
      pwr_cnt_q   <= '0;
      lock_q      <= 1'b0;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      byte_last_q <= 1'b0;
`ifdef CLCD_INIT_SEQ_EN
      idx_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      lock_q      <= lock_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      byte_last_q <= byte_last_d;
`ifdef CLCD_INIT_SEQ_EN
      idx_q       <= idx_d;
`endif
    end
  end

  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;
  assign busy       = (state_q != IDLE) || !tmr_idle;
  assign grant_id   = accept ? gnt_id : grant_q;
  assign LCD_RW     = 1'b0;

endmodule

// File: tb/tb_clcd_req_arbiter.sv
// Directed self-checking bench for clcd_req_arbiter with short timing parameters.
// Latency: expectations are hand-derived gaps between ready pulses and reset release.
// Backpressure: requesters hold valid until ready, as the design expects.
module tb_clcd_req_arbiter;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_rs, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       busy, grant_id;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef CLCD_INIT_SEQ_EN
  localparam int EXP_BUSY_AT = 8 + 3 * 9 + 15;
  localparam int EXP_PULSES  = 4;
`else
  localparam int EXP_BUSY_AT = 8;
  localparam int EXP_PULSES  = 0;
`endif

  clcd_req_arbiter #(
    .SETUP_CYC   (1),
    .PULSE_CYC   (2),
    .HOLD_CYC    (1),
    .EXEC_CYC    (4),
    .LONG_CYC    (10),
    .POWERUP_CYC (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_rs    (req0_rs),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rs    (req1_rs),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .busy       (busy),
    .grant_id   (grant_id),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_DATA   (LCD_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req0(input logic v, input logic rs, input logic [7:0] d, input logic l);
    req0_valid = v; req0_rs = rs; req0_data = d; req0_last = l;
  endtask

  task automatic set_req1(input logic v, input logic rs, input logic [7:0] d, input logic l);
    req1_valid = v; req1_rs = rs; req1_data = d; req1_last = l;
  endtask

  task automatic wait_idle(input string tag);
    int seen = 0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) seen = 1;
    end
    total_cnt++;
    if (seen !== 1) $display("FAIL %s_idle: busy never fell within 100 cycles", tag);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req0(1'b0, 1'b0, 8'h00, 1'b1);
    set_req1(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    set_req0(1'b1, 1'b1, 8'h11, 1'b1);
    set_req1(1'b1, 1'b1, 8'h22, 1'b1);
    #1;
    total_cnt++; if (LCD_E !== 1'b0) $display("FAIL rst_e: got %b want 0", LCD_E); else pass_cnt++;
    total_cnt++; if (LCD_RS !== 1'b0) $display("FAIL rst_rs: got %b want 0", LCD_RS); else pass_cnt++;
    total_cnt++; if (LCD_RW !== 1'b0) $display("FAIL rst_rw: got %b want 0", LCD_RW); else pass_cnt++;
    total_cnt++; if (LCD_DATA !== 8'h00) $display("FAIL rst_data: got %h want 00", LCD_DATA); else pass_cnt++;
    total_cnt++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL rst_ready: got %b%b want 00", req1_ready, req0_ready);
    else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (grant_id !== 1'b0) $display("FAIL rst_grant: got %b want 0", grant_id); else pass_cnt++;
  endtask

  // Releases reset and watches the power-up / init sequence until busy falls
  task automatic test_powerup(input string tag);
    int         busy_at = -1;
    int         npulse  = 0;
    int         elen    = 0;
    int         len_bad = 0;
    int         rw_bad  = 0;
    logic       e_prev  = 1'b0;
    logic [7:0] pdat [8];
    logic       prs  [8];
    logic [7:0] exp_tab [4];
    exp_tab = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 8; i++) begin pdat[i] = 8'hxx; prs[i] = 1'bx; end
    @(negedge clk);
    set_req0(1'b0, 1'b0, 8'h00, 1'b1);
    set_req1(1'b0, 1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    for (int n = 1; n <= 200 && busy_at < 0; n++) begin
      @(negedge clk);
      if (LCD_RW !== 1'b0) rw_bad++;
      if (LCD_E === 1'b1 && e_prev !== 1'b1) begin
        if (npulse < 8) begin pdat[npulse] = LCD_DATA; prs[npulse] = LCD_RS; end
        npulse++;
        elen = 0;
      end
      if (LCD_E === 1'b1) elen++;
      if (LCD_E !== 1'b1 && e_prev === 1'b1 && elen != 2) len_bad++;
      e_prev = LCD_E;
      if (busy === 1'b0) busy_at = n;
    end
    total_cnt++;
    if (busy_at != EXP_BUSY_AT) $display("FAIL %s_busy_fall: got %0d want %0d", tag, busy_at, EXP_BUSY_AT);
    else pass_cnt++;
    total_cnt++;
    if (npulse != EXP_PULSES) $display("FAIL %s_pulses: got %0d want %0d", tag, npulse, EXP_PULSES);
    else pass_cnt++;
    total_cnt++;
    if (len_bad != 0 || rw_bad != 0) $display("FAIL %s_shape: got len_bad=%0d rw_bad=%0d want 0", tag, len_bad, rw_bad);
    else pass_cnt++;
`ifdef CLCD_INIT_SEQ_EN
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (pdat[i] !== exp_tab[i] || prs[i] !== 1'b0)
        $display("FAIL %s_init%0d: got rs=%b data=%h want rs=0 data=%h", tag, i, prs[i], pdat[i], exp_tab[i]);
      else pass_cnt++;
    end
`endif
  endtask

  // One byte with a follow-up byte waiting: checks pulse shape and minimum spacing
  task automatic run_gap(input string tag, input logic rs, input logic [7:0] d, input int exp_gap);
    int   gap = 0;
    int   e_cnt = 0;
    logic bad = 1'b0;
    @(negedge clk);
    set_req0(1'b1, rs, d, 1'b1);
    #1;
    total_cnt++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || grant_id !== 1'b0)
      $display("FAIL %s_ready: got r0=%b r1=%b gid=%b want 1 0 0", tag, req0_ready, req1_ready, grant_id);
    else pass_cnt++;
    @(negedge clk);
    set_req0(1'b1, 1'b1, 8'h42, 1'b1);
    for (int k = 1; k <= 40 && gap == 0; k++) begin
      #1;
      if (req0_ready === 1'b1) gap = k;
      else if (LCD_E === 1'b1) begin
        e_cnt++;
        if (LCD_RS !== rs || LCD_DATA !== d) bad = 1'b1;
      end
      if (gap == 0) @(negedge clk);
    end
    total_cnt++;
    if (gap != exp_gap) $display("FAIL %s_gap: got %0d want %0d", tag, gap, exp_gap); else pass_cnt++;
    total_cnt++;
    if (e_cnt != 2) $display("FAIL %s_e_len: got %0d want 2", tag, e_cnt); else pass_cnt++;
    total_cnt++;
    if (bad !== 1'b0) $display("FAIL %s_bus: RS/DATA differed from rs=%b data=%h during E", tag, rs, d);
    else pass_cnt++;
    @(negedge clk);
    set_req0(1'b0, 1'b0, 8'h00, 1'b1);
    wait_idle(tag);
  endtask

  task automatic test_single_byte();
    run_gap("single", 1'b1, 8'h41, 9);
  endtask

  task automatic test_long_wait();
    run_gap("clear", 1'b0, 8'h01, 15);
  endtask

  // Both requesters always valid: grants must alternate, starting with req1 since req0 went last
  task automatic test_round_robin();
    int   np = 0;
    logic gid [4];
    logic r0 [4];
    logic r1 [4];
    @(negedge clk);
    set_req0(1'b1, 1'b1, 8'h61, 1'b1);
    set_req1(1'b1, 1'b1, 8'h62, 1'b1);
    for (int k = 0; k < 100 && np < 4; k++) begin
      #1;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        gid[np] = grant_id; r0[np] = req0_ready; r1[np] = req1_ready; np++;
      end
      if (np < 4) @(negedge clk);
    end
    @(negedge clk);
    set_req0(1'b0, 1'b0, 8'h00, 1'b1);
    set_req1(1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (np != 4) $display("FAIL rr_count: got %0d pulses want 4", np); else pass_cnt++;
    for (int i = 0; i < np; i++) begin
      total_cnt++;
      if (gid[i] !== ((i % 2 == 0) ? 1'b1 : 1'b0) || r1[i] !== gid[i] || r0[i] !== ~gid[i])
        $display("FAIL rr_grant%0d: got gid=%b r0=%b r1=%b want gid=%b", i, gid[i], r0[i], r1[i],
                 (i % 2 == 0) ? 1'b1 : 1'b0);
      else pass_cnt++;
    end
    wait_idle("rr");
  endtask

  // req1 opens a burst; req0 must wait until the closing byte has finished its WAIT
  task automatic test_lock();
    int   t0 = 0;
    int   t1 = 0;
    logic gmid = 1'bx;
    @(negedge clk);
    set_req1(1'b1, 1'b1, 8'h80, 1'b0);
    #1;
    total_cnt++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
      $display("FAIL lock_first: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
    else pass_cnt++;
    @(negedge clk);
    set_req1(1'b1, 1'b1, 8'h48, 1'b1);
    set_req0(1'b1, 1'b1, 8'h30, 1'b1);
    for (int k = 1; k <= 60 && t0 == 0; k++) begin
      #1;
      if (k == 5) gmid = grant_id;
      if (req1_ready === 1'b1 && t1 == 0) t1 = k;
      if (req0_ready === 1'b1) t0 = k;
      @(negedge clk);
      if (t1 != 0) req1_valid = 1'b0;
    end
    set_req0(1'b0, 1'b0, 8'h00, 1'b1);
    total_cnt++;
    if (t1 != 9) $display("FAIL lock_second: req1 ready at %0d want 9", t1); else pass_cnt++;
    total_cnt++;
    if (t0 != 18) $display("FAIL lock_wait: req0 ready at %0d want 18", t0); else pass_cnt++;
    total_cnt++;
    if (gmid !== 1'b1) $display("FAIL lock_gid: got %b want 1", gmid); else pass_cnt++;
    wait_idle("lock");
  endtask

  // Reset in the middle of a pulse must kill E at once and restart power-up
  task automatic test_reset_mid_pulse();
    int seen = 0;
    @(negedge clk);
    set_req0(1'b1, 1'b1, 8'h55, 1'b1);
    @(negedge clk);
    set_req0(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 20 && seen == 0; k++) begin
      #1;
      if (LCD_E === 1'b1) seen = 1;
      else @(negedge clk);
    end
    total_cnt++;
    if (seen != 1) $display("FAIL midrst_pulse: LCD_E never rose"); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (LCD_E !== 1'b0) $display("FAIL midrst_e: got %b want 0", LCD_E); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL midrst_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++;
    if (LCD_DATA !== 8'h00 || grant_id !== 1'b0)
      $display("FAIL midrst_outs: got data=%h gid=%b want 00 0", LCD_DATA, grant_id);
    else pass_cnt++;
    test_powerup("repwr");
  endtask

  initial begin
    test_reset();
    test_powerup("pwr");
    test_single_byte();
    test_round_robin();
    test_lock();
    test_long_wait();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
